// File: rtl/stall_ctrl_pkg.sv
// Shared defaults and types for the D-stage hazard/stall controller.
package stall_ctrl_pkg;

  localparam int unsigned TW_DEF = 2;
  localparam int unsigned RW_DEF = 5;

  // Tuse value meaning "operand not read" at the default Tnew/Tuse width
  localparam logic [TW_DEF-1:0] TUSE_NONE = '1;

  // One tracked pipeline stage: is it live, what does it write, when is it ready
  typedef struct packed {
    logic              valid;
    logic [RW_DEF-1:0] dst;
    logic [TW_DEF-1:0] tnew;
  } stage_t;

endpackage

// File: rtl/stall_ctrl_if.sv
// D-stage hazard query bus: decode-side operand info in, stall/forward decisions out.
interface stall_ctrl_if #(
  parameter int unsigned RW = 5,
  parameter int unsigned TW = 2,
  parameter int unsigned FW = 2,
  parameter int unsigned CW = 32
);

  logic          d_valid;
  logic [RW-1:0] d_rs;
  logic [RW-1:0] d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [RW-1:0] d_dst;
  logic [TW-1:0] d_tnew;
  logic          flush;
  logic          stall;
  logic [FW-1:0] fwd_rs;
  logic [FW-1:0] fwd_rt;
  logic [CW-1:0] stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, flush,
    input  stall, fwd_rs, fwd_rt, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, flush,
    output stall, fwd_rs, fwd_rt, stall_cnt
  );

endinterface

// File: rtl/stall_ctrl_stage.sv
// One tracked pipeline stage: captures {valid, dst, tnew} with tnew counting down to zero.
module stall_stage
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned RW = RW_DEF,
  parameter int unsigned TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [RW-1:0] in_dst,
  input  logic [TW-1:0] in_tnew,
  output logic          q_valid,
  output logic [RW-1:0] q_dst,
  output logic [TW-1:0] q_tnew
);

  // Load the upstream entry, ageing its ready-countdown by one cycle (floor at zero)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_dst   <= '0;
      q_tnew  <= '0;
    end else begin
      q_valid <= in_valid;
      q_dst   <= in_dst;
      q_tnew  <= (in_tnew == '0) ? '0 : in_tnew - TW'(1);
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Decode-stage hazard unit: tracks in-flight writers, decides stall and forwarding source.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned TW     = TW_DEF,
  parameter int unsigned RW     = RW_DEF,
  parameter int unsigned CW     = 32
) (
  input logic         clk,
  input logic         rst_n,
  stall_ctrl_if.slave bus
);

  localparam int unsigned FW = $clog2(NSTAGE + 1);
  // All-ones Tuse at this instance's width marks an operand that is not read
  localparam logic [TW-1:0] TUSE_OFF = '1;

  logic          s_valid [NSTAGE];
  logic [RW-1:0] s_dst   [NSTAGE];
  logic [TW-1:0] s_tnew  [NSTAGE];
  logic          n_valid [NSTAGE];
  logic [RW-1:0] n_dst   [NSTAGE];
  logic [TW-1:0] n_tnew  [NSTAGE];

  logic          live;
  logic          issue;
  logic          m_rs;
  logic          m_rt;
  logic          seen_rs;
  logic          seen_rt;
  logic          stall_c;
  logic [FW-1:0] fwd_rs_c;
  logic [FW-1:0] fwd_rt_c;
  logic [CW-1:0] cnt;

  // Holding rst_n low suppresses any hazard decision from stale stage contents
  assign live = rst_n & bus.d_valid;

  // Stage 1 takes the D instruction only when it advances; otherwise a bubble
  always_comb begin
    issue      = bus.d_valid & ~stall_c & ~bus.flush;
    n_valid[0] = issue;
    n_dst[0]   = issue ? bus.d_dst  : '0;
    n_tnew[0]  = issue ? bus.d_tnew : '0;
    for (int unsigned i = 1; i < NSTAGE; i++) begin
      n_valid[i] = s_valid[i-1];
      n_dst[i]   = s_dst[i-1];
      n_tnew[i]  = s_tnew[i-1];
    end
  end

  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    stall_stage #(
      .RW (RW),
      .TW (TW)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (n_valid[g]),
      .in_dst   (n_dst[g]),
      .in_tnew  (n_tnew[g]),
      .q_valid  (s_valid[g]),
      .q_dst    (s_dst[g]),
      .q_tnew   (s_tnew[g])
    );
  end

  // Match each operand against stages youngest-first; only the youngest writer may forward
  always_comb begin
    stall_c  = 1'b0;
    fwd_rs_c = '0;
    fwd_rt_c = '0;
    seen_rs  = 1'b0;
    seen_rt  = 1'b0;
    m_rs     = 1'b0;
    m_rt     = 1'b0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      m_rs = live & s_valid[i] & (s_dst[i] != '0) & (s_dst[i] == bus.d_rs)
           & (bus.d_tuse_rs != TUSE_OFF);
      m_rt = live & s_valid[i] & (s_dst[i] != '0) & (s_dst[i] == bus.d_rt)
           & (bus.d_tuse_rt != TUSE_OFF);
      if (m_rs && (s_tnew[i] > bus.d_tuse_rs)) stall_c = 1'b1;
      if (m_rt && (s_tnew[i] > bus.d_tuse_rt)) stall_c = 1'b1;
      if (m_rs && !seen_rs) begin
        seen_rs = 1'b1;
        if (s_tnew[i] == '0) fwd_rs_c = FW'(i + 1);
      end
      if (m_rt && !seen_rt) begin
        seen_rt = 1'b1;
        if (s_tnew[i] == '0) fwd_rt_c = FW'(i + 1);
      end
    end
  end

  // Stalled-cycle counter, sticks at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (stall_c && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bus.stall     = stall_c;
  assign bus.fwd_rs    = fwd_rs_c;
  assign bus.fwd_rt    = fwd_rt_c;
  assign bus.stall_cnt = cnt;

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter NSTAGE, default 3: tracked stages after D (1=E, 2=M, 3=W).
REQ-002 Parameter TW, default 2: Tnew/Tuse width; all-ones Tuse means operand unused.
REQ-003 Parameter RW, default 5: register address width.
REQ-004 Parameter CW, default 32: stall counter width.
REQ-005 Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- d_valid  in  1  D-stage instruction present.
- d_rs, d_rt  in  RW each  source register addresses.
- d_tuse_rs, d_tuse_rt  in  TW each  cycles until operand is needed; all-ones = unused.
- d_dst  in  RW  destination register; 0 = no write.
- d_tnew  in  TW  cycles until result is ready, counted from D.
- flush  in  1  force a bubble into E at the next edge.
- stall  out  1  freeze F/D; insert bubble into E.
- fwd_rs, fwd_rt  out  clog2(NSTAGE+1)  stage to forward from for a D-stage read; 0 = register file.
- stall_cnt  out  CW  count of stalled cycles.

Function
REQ-006 Each stage k=1..NSTAGE holds valid, dst (RW) and tnew (TW).
REQ-007 Stage k>=2 loads stage k-1 every edge, with tnew = saturating decrement (0 stays 0).
REQ-008 Stage 1 loads d_valid, d_dst and sat_dec(d_tnew) when stall=0, flush=0 and d_valid=1.
REQ-009 Otherwise stage 1 loads a bubble: valid=0, dst=0, tnew=0.
REQ-010 A match on stage k for operand r requires all of: stage valid, dst != 0, dst == r, d_valid=1 and the operand's Tuse != all-ones.
REQ-011 stall=1 when some stage k matches rs with tnew_k > d_tuse_rs, or matches rt with tnew_k > d_tuse_rt.
REQ-012 stall is purely combinational from current state and inputs.
REQ-013 fwd_rs = smallest k matching rs; it is nonzero only if that stage has tnew_k == 0.
REQ-014 If the youngest match has tnew>0, fwd_rs=0: no fallback to an older stage.
REQ-015 fwd_rt follows the same rules using rt.
REQ-016 Register 0 never causes a stall or a forward.
REQ-017 Simultaneous flush and stall: the bubble is inserted once; the stall is still counted.
REQ-018 stall_cnt increments by 1 on each edge where stall=1.
REQ-019 stall_cnt saturates at all-ones and does not wrap.
REQ-020 Outputs are valid in the same cycle as D inputs; there is no added latency.

Reset
REQ-021 rst_n=0 at an edge clears all stage valid/dst/tnew fields and stall_cnt to 0.
REQ-022 During reset, stall=0 and fwd_rs=fwd_rt=0 because no stage is valid.
REQ-023 Reset asserted mid-stall discards all in-flight stage state; the first post-reset cycle never stalls.

Structure
REQ-024 A shared package holds the TW/RW defaults, the TUSE_NONE constant (all-ones) and the stage-entry struct {valid, dst, tnew}.
REQ-025 One sub-module, stall_stage, implements a single stage register with the saturating-decrement load.
REQ-026 The top level instantiates NSTAGE copies of stall_stage via generate.
REQ-027 Match, priority and stall logic live in the top level.
REQ-028 Target size is 120-400 RTL lines.

Verification
REQ-029 Load-use: lw $1 (d_tnew=3), then addu rs=$1 (tuse=1) -> stall=1 for exactly 1 cycle; next cycle stall=0 and stall_cnt=1.
REQ-030 Branch after ALU: addu $1 (tnew=2), then beq rs=$1 (tuse=0) -> stall 1 cycle; then fwd_rs=2 (M), stall=0.
REQ-031 Register zero: d_dst=0 in stages 1..3 and d_rs=0 -> stall=0, fwd_rs=0 in every cycle.
REQ-032 Priority: $5 written by stages 1 (tnew=0) and 2 (tnew=0) -> fwd_rt=1. With stage 1 tnew=1 and tuse_rt=2 -> fwd_rt=0, stall=0.
REQ-033 Flush and reset: flush=1 during a stall -> stage 1 valid=0 next cycle. rst_n=0 mid-stall -> stall=0 and stall_cnt=0 after the edge.
REQ-034 Saturation and parameters: CW=4 with 20 stall cycles -> stall_cnt=15. Rerun the load-use scenario with NSTAGE=5, TW=3 -> same stall count.
